// File: rtl/code_lock_n.sv
// N-digit keypad code lock with fail counting and timed alarm lockout; outputs registered, 1-cycle latency.
// Optional auto-relock of an idle open door is built when AUTO_RELOCK_EN is defined.
module code_lock_n #(
    parameter int DIGITS         = 4,
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 1024,
    parameter int RELOCK_CYCLES  = 4096
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [9:0]            KEY,
    input  logic                  OPEN,
    input  logic                  CLOSE,
    input  logic                  SET,
    output logic                  UNLOCKED,
    output logic                  ALARM,
    output logic [4*DIGITS-1:0]   ENTRY,
    output logic [3:0]            ENTRY_CNT,
    output logic [3:0]            TRIES_LEFT
);

    localparam int LW = $clog2(LOCKOUT_CYCLES);

    if (DIGITS < 1 || DIGITS > 8 || MAX_TRIES < 1 || MAX_TRIES > 15 ||
        LOCKOUT_CYCLES < 2 || RELOCK_CYCLES < 2) begin : g_bad_param
        $error("code_lock_n: parameter out of range");
    end

    typedef enum logic [1:0] {S_LOCKED, S_OPENED, S_LOCKOUT} state_t;

    state_t                r_state, w_state_nxt;
    logic [9:0]            r_key_prev;
    logic                  r_open_prev;
    logic [4*DIGITS-1:0]   r_entry, w_entry_nxt;
    logic [4*DIGITS-1:0]   r_code, w_code_nxt;
    logic [3:0]            r_cnt, w_cnt_nxt;
    logic [3:0]            r_fails, w_fails_nxt;
    logic [LW-1:0]         r_lock_cnt, w_lock_nxt;
    logic                  r_unlocked, r_alarm;
    logic [3:0]            r_tries_left;

    logic [3:0]            w_digit;
    logic                  w_onehot, w_full, w_open_edge;
    logic                  w_key_acc, w_set_ev, w_close_ev, w_open_ev;

`ifdef AUTO_RELOCK_EN
    localparam int RW = $clog2(RELOCK_CYCLES);
    logic [RW-1:0]         r_idle, w_idle_nxt;
`endif

    always_comb begin
        w_digit = '0;
        for (int i = 0; i < 10; i++) begin
            if (KEY[i]) w_digit = 4'(i);
        end
    end

    // A press only counts after a cycle of all-keys-released, so chords and held keys never re-trigger.
    assign w_onehot    = (KEY != '0) && ((KEY & (KEY - 10'd1)) == '0);
    assign w_full      = (r_cnt == 4'(DIGITS));
    assign w_open_edge = OPEN && !r_open_prev;
    assign w_key_acc   = w_onehot && (r_key_prev == '0) && !w_full && (r_state != S_LOCKOUT);
    assign w_set_ev    = SET && (r_state == S_OPENED);
    assign w_close_ev  = CLOSE && (r_state != S_LOCKOUT);
    assign w_open_ev   = w_open_edge && (r_state == S_LOCKED);

    always_comb begin
        w_state_nxt = r_state;
        w_entry_nxt = r_entry;
        w_code_nxt  = r_code;
        w_cnt_nxt   = r_cnt;
        w_fails_nxt = r_fails;
        w_lock_nxt  = r_lock_cnt;
`ifdef AUTO_RELOCK_EN
        w_idle_nxt  = r_idle;
`endif
        if (r_state == S_LOCKOUT) begin
            if (r_lock_cnt == '0) begin
                w_state_nxt = S_LOCKED;
                w_fails_nxt = '0;
            end else begin
                w_lock_nxt = r_lock_cnt - LW'(1);
            end
        end else if (w_key_acc) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (r_cnt == 4'(d)) w_entry_nxt[4*d +: 4] = w_digit;
            end
            w_cnt_nxt = r_cnt + 4'd1;
`ifdef AUTO_RELOCK_EN
            w_idle_nxt = '0;
`endif
        end else if (w_set_ev) begin
            if (w_full) begin
                w_code_nxt  = r_entry;
                w_entry_nxt = '0;
                w_cnt_nxt   = '0;
            end
`ifdef AUTO_RELOCK_EN
            w_idle_nxt = '0;
`endif
        end else if (w_close_ev) begin
            w_state_nxt = S_LOCKED;
            w_entry_nxt = '0;
            w_cnt_nxt   = '0;
        end else if (w_open_ev) begin
            w_entry_nxt = '0;
            w_cnt_nxt   = '0;
            if (w_full && (r_entry == r_code)) begin
                w_state_nxt = S_OPENED;
                w_fails_nxt = '0;
`ifdef AUTO_RELOCK_EN
                w_idle_nxt  = '0;
`endif
            end else begin
                w_fails_nxt = r_fails + 4'd1;
                if (r_fails + 4'd1 == 4'(MAX_TRIES)) begin
                    w_state_nxt = S_LOCKOUT;
                    w_lock_nxt  = LW'(LOCKOUT_CYCLES - 1);
                end
            end
        end
`ifdef AUTO_RELOCK_EN
        else if (r_state == S_OPENED) begin
            if (w_open_edge) begin
                w_idle_nxt = '0;
            end else if (r_idle == RW'(RELOCK_CYCLES - 1)) begin
                w_state_nxt = S_LOCKED;
                w_entry_nxt = '0;
                w_cnt_nxt   = '0;
            end else begin
                w_idle_nxt = r_idle + RW'(1);
            end
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= S_LOCKED;
            r_key_prev   <= '0;
            r_open_prev  <= 1'b0;
            r_entry      <= '0;
            r_code       <= '0;
            r_cnt        <= '0;
            r_fails      <= '0;
            r_lock_cnt   <= '0;
            r_unlocked   <= 1'b0;
            r_alarm      <= 1'b0;
            r_tries_left <= 4'(MAX_TRIES);
`ifdef AUTO_RELOCK_EN
            r_idle       <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_key_prev   <= KEY;
            r_open_prev  <= OPEN;
            r_entry      <= w_entry_nxt;
            r_code       <= w_code_nxt;
            r_cnt        <= w_cnt_nxt;
            r_fails      <= w_fails_nxt;
            r_lock_cnt   <= w_lock_nxt;
            r_unlocked   <= (w_state_nxt == S_OPENED);
            r_alarm      <= (w_state_nxt == S_LOCKOUT);
            r_tries_left <= (w_state_nxt == S_LOCKOUT) ? 4'd0 : 4'(MAX_TRIES) - w_fails_nxt;
`ifdef AUTO_RELOCK_EN
            r_idle       <= w_idle_nxt;
`endif
        end
    end

    assign UNLOCKED   = r_unlocked;
    assign ALARM      = r_alarm;
    assign ENTRY      = r_entry;
    assign ENTRY_CNT  = r_cnt;
    assign TRIES_LEFT = r_tries_left;

endmodule

// File: tb/tb_code_lock_n.sv
// Directed bench for code_lock_n (DIGITS=4, MAX_TRIES=3, LOCKOUT_CYCLES=16, RELOCK_CYCLES=8).
module tb_code_lock_n;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [9:0]  KEY = '0;
    logic        OPEN = 1'b0, CLOSE = 1'b0, SET = 1'b0;
    logic        UNLOCKED, ALARM;
    logic [15:0] ENTRY;
    logic [3:0]  ENTRY_CNT, TRIES_LEFT;

    int n_chk = 0;
    int n_fail = 0;

    code_lock_n #(.DIGITS(4), .MAX_TRIES(3), .LOCKOUT_CYCLES(16), .RELOCK_CYCLES(8)) dut (
        .CLK(CLK), .RESET(RESET), .KEY(KEY), .OPEN(OPEN), .CLOSE(CLOSE), .SET(SET),
        .UNLOCKED(UNLOCKED), .ALARM(ALARM), .ENTRY(ENTRY), .ENTRY_CNT(ENTRY_CNT),
        .TRIES_LEFT(TRIES_LEFT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [9:0]  key;
        logic        op, cl, st;
        logic        unl, alm;
        logic [3:0]  cnt, tries;
        logic [15:0] entry;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [9:0] kp(input int d);
        logic [9:0] one;
        one = 10'd1;
        return one << d;
    endfunction

    function automatic void add(input logic [9:0] k, input logic o, c, s, u, a,
                                input logic [3:0] n, t, input logic [15:0] e);
        tbl.push_back('{k, o, c, s, u, a, n, t, e});
    endfunction

    // press digit d for one cycle, then release; expectations hold for both cycles
    function automatic void addp(input int d, input logic u, a, input logic [3:0] n, t,
                                 input logic [15:0] e);
        add(kp(d), 0, 0, 0, u, a, n, t, e);
        add('0, 0, 0, 0, u, a, n, t, e);
    endfunction

    task automatic step(input logic [9:0] k, input logic o, c, s);
        KEY = k; OPEN = o; CLOSE = c; SET = s;
        @(posedge CLK);
        #1;
    endtask

    task automatic press(input int d);
        step(kp(d), 0, 0, 0);
        step('0, 0, 0, 0);
    endtask

    task automatic check(input string nm, input logic u, a, input logic [3:0] n, t,
                         input logic [15:0] e);
        n_chk++;
        if ({UNLOCKED, ALARM, ENTRY_CNT, TRIES_LEFT, ENTRY} !== {u, a, n, t, e}) begin
            n_fail++;
            $display("FAIL %s: got unl=%0b alm=%0b cnt=%0d tries=%0d entry=%h, want unl=%0b alm=%0b cnt=%0d tries=%0d entry=%h",
                     nm, UNLOCKED, ALARM, ENTRY_CNT, TRIES_LEFT, ENTRY, u, a, n, t, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] t;
        // default code 0000 unlocks
        addp(0, 0, 0, 1, 3, 16'h0); addp(0, 0, 0, 2, 3, 16'h0);
        addp(0, 0, 0, 3, 3, 16'h0); addp(0, 0, 0, 4, 3, 16'h0);
        add('0, 1, 0, 0, 1, 0, 0, 3, 16'h0); add('0, 0, 0, 0, 1, 0, 0, 3, 16'h0);
        // store 1234, close, reopen with it, then a wrong code
        addp(1, 1, 0, 1, 3, 16'h0001); addp(2, 1, 0, 2, 3, 16'h0021);
        addp(3, 1, 0, 3, 3, 16'h0321); addp(4, 1, 0, 4, 3, 16'h4321);
        add('0, 0, 0, 1, 1, 0, 0, 3, 16'h0); add('0, 0, 1, 0, 0, 0, 0, 3, 16'h0);
        addp(1, 0, 0, 1, 3, 16'h0001); addp(2, 0, 0, 2, 3, 16'h0021);
        addp(3, 0, 0, 3, 3, 16'h0321); addp(4, 0, 0, 4, 3, 16'h4321);
        add('0, 1, 0, 0, 1, 0, 0, 3, 16'h0); add('0, 0, 1, 0, 0, 0, 0, 3, 16'h0);
        addp(1, 0, 0, 1, 3, 16'h0001); addp(2, 0, 0, 2, 3, 16'h0021);
        addp(3, 0, 0, 3, 3, 16'h0321); addp(5, 0, 0, 4, 3, 16'h5321);
        add('0, 1, 0, 0, 0, 0, 0, 2, 16'h0); add('0, 0, 0, 0, 0, 0, 0, 2, 16'h0);
        // correct code clears the fail count
        addp(1, 0, 0, 1, 2, 16'h0001); addp(2, 0, 0, 2, 2, 16'h0021);
        addp(3, 0, 0, 3, 2, 16'h0321); addp(4, 0, 0, 4, 2, 16'h4321);
        add('0, 1, 0, 0, 1, 0, 0, 3, 16'h0); add('0, 0, 1, 0, 0, 0, 0, 3, 16'h0);
        // three wrong codes -> lockout
        for (int w = 0; w < 3; w++) begin
            t = 4'(3 - w);
            addp(1, 0, 0, 1, t, 16'h0001); addp(1, 0, 0, 2, t, 16'h0011);
            addp(1, 0, 0, 3, t, 16'h0111); addp(1, 0, 0, 4, t, 16'h1111);
            add('0, 1, 0, 0, 0, (w == 2), 0, t - 4'd1, 16'h0);
        end
        add('0, 0, 0, 0, 0, 1, 0, 0, 16'h0);
        addp(1, 0, 1, 0, 0, 16'h0); addp(2, 0, 1, 0, 0, 16'h0);
        addp(3, 0, 1, 0, 0, 16'h0); addp(4, 0, 1, 0, 0, 16'h0);
        add('0, 1, 0, 0, 0, 1, 0, 0, 16'h0); add('0, 0, 0, 0, 0, 1, 0, 0, 16'h0);
        for (int i = 0; i < 4; i++) add(kp(2), 0, 0, 0, 0, 1, 0, 0, 16'h0);
        add(kp(2), 0, 0, 0, 0, 0, 0, 3, 16'h0);
        add(kp(2), 0, 0, 0, 0, 0, 0, 3, 16'h0);
        add('0, 0, 0, 0, 0, 0, 0, 3, 16'h0);
        addp(1, 0, 0, 1, 3, 16'h0001); addp(2, 0, 0, 2, 3, 16'h0021);
        addp(3, 0, 0, 3, 3, 16'h0321); addp(4, 0, 0, 4, 3, 16'h4321);
        add('0, 1, 0, 0, 1, 0, 0, 3, 16'h0); add('0, 0, 0, 0, 1, 0, 0, 3, 16'h0);

        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        check("reset", 0, 0, 0, 3, 16'h0);

        foreach (tbl[i]) begin
            step(tbl[i].key, tbl[i].op, tbl[i].cl, tbl[i].st);
            check($sformatf("vec%0d", i), tbl[i].unl, tbl[i].alm, tbl[i].cnt, tbl[i].tries, tbl[i].entry);
        end

        // held key, chord, saturation
        step('0, 0, 1, 0);
        check("close", 0, 0, 0, 3, 16'h0);
        for (int i = 0; i < 5; i++) begin
            step(kp(7), 0, 0, 0);
            check($sformatf("hold7_%0d", i), 0, 0, 1, 3, 16'h0007);
        end
        step('0, 0, 0, 0);
        step(kp(3) | kp(4), 0, 0, 0);
        check("chord", 0, 0, 1, 3, 16'h0007);
        step(kp(3), 0, 0, 0);
        check("chord_drop", 0, 0, 1, 3, 16'h0007);
        step('0, 0, 0, 0);
        for (int d = 1; d <= 6; d++) press(d);
        check("saturate", 0, 0, 4, 3, 16'h3217);

        // key accept beats OPEN; OPEN held does not re-evaluate
        step('0, 0, 1, 0);
        press(1); press(2); press(3);
        step(kp(4), 1, 0, 0);
        check("key_over_open", 0, 0, 4, 3, 16'h4321);
        step('0, 1, 0, 0);
        check("open_held", 0, 0, 4, 3, 16'h4321);
        step('0, 0, 0, 0);
        step('0, 1, 0, 0);
        check("open_edge", 1, 0, 0, 3, 16'h0);
        step('0, 0, 0, 0);
        press(5); press(6); press(7); press(8);
        step('0, 0, 1, 1);
        check("set_over_close", 1, 0, 0, 3, 16'h0);
        step('0, 0, 0, 0);
        step('0, 0, 1, 0);
        check("close2", 0, 0, 0, 3, 16'h0);
        press(5); press(6); press(7); press(8);
        step('0, 1, 0, 0);
        check("new_code", 1, 0, 0, 3, 16'h0);

`ifdef AUTO_RELOCK_EN
        for (int k = 1; k <= 8; k++) begin
            step('0, 0, 0, 0);
            if (k == 7) check("relock_k7", 1, 0, 0, 3, 16'h0);
            if (k == 8) check("relock_k8", 0, 0, 0, 3, 16'h0);
        end
        press(5); press(6); press(7); press(8);
        step('0, 1, 0, 0);
        check("reopen", 1, 0, 0, 3, 16'h0);
        for (int k = 1; k <= 13; k++) begin
            step((k == 5) ? kp(9) : 10'd0, 0, 0, 0);
            if (k == 12) check("relock_k12", 1, 0, 1, 3, 16'h0009);
            if (k == 13) check("relock_k13", 0, 0, 0, 3, 16'h0);
        end
`else
        for (int k = 1; k <= 20; k++) step('0, 0, 0, 0);
        check("no_relock", 1, 0, 0, 3, 16'h0);
`endif

        // empty-entry OPENs fail; reset aborts lockout and restores code 0000
        step('0, 0, 1, 0);
        step('0, 1, 0, 0);
        check("empty_open", 0, 0, 0, 2, 16'h0);
        step('0, 0, 0, 0);
        step('0, 1, 0, 0); step('0, 0, 0, 0);
        step('0, 1, 0, 0);
        check("lockout2", 0, 1, 0, 0, 16'h0);
        step('0, 0, 0, 0);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        check("reset_lockout", 0, 0, 0, 3, 16'h0);
        press(0); press(0); press(0); press(0);
        step('0, 1, 0, 0);
        check("code_reset", 1, 0, 0, 3, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
